// File: rtl/data_ram_pkg.sv
// data_ram_pkg
// Shared types and helpers for the data_ram slice.
//   state_t     : sequencer state (CLEAR sweeps the array, IDLE serves requests)
//   lanes()     : number of 8-bit byte lanes in a word of the given width
package data_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Byte lanes per word; the word width is always a whole number of bytes.
    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// data_ram_array
// DEPTH x DATA_W storage with one byte-lane-masked write port and two
// combinational read ports (one for the access path, one for debug).
// Ports:
//   clk              : clock, writes land on the rising edge
//   wr_en            : write strobe; caller guarantees wr_addr < DEPTH
//   wr_addr/wr_data  : write address and data
//   wr_be            : per-lane write enables, bit i covers wr_data[8i+7:8i]
//   rd_addr/rd_data  : access read port, 0 when rd_addr >= DEPTH
//   dbg_addr/dbg_data: debug read port, 0 when dbg_addr >= DEPTH
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [lanes(DATA_W)-1:0]    wr_be,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    input  logic [ADDR_W-1:0]           dbg_addr,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam int LANES = lanes(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Lane-masked write; untouched lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Both read ports are asynchronous, so a word written this edge shows
    // its old value until the edge has passed.
    always_comb begin
        rd_data  = '0;
        dbg_data = '0;
        if ({1'b0, rd_addr} < DEPTH_L) begin
            rd_data = mem[rd_addr];
        end
        if ({1'b0, dbg_addr} < DEPTH_L) begin
            dbg_data = mem[dbg_addr];
        end
    end

endmodule

// File: rtl/data_ram.sv
// data_ram
// Single-port data memory with byte-lane writes, a registered read port,
// a range-checked handshake and a clear sequencer that zeroes every word
// after reset or on a soft clear request.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   clr               : soft clear request, starts a full sweep from IDLE
//   req, we, addr     : access request, write/read select, word address
//   din, be           : write data and per-byte-lane enables
//   ready             : a request presented this cycle will be accepted
//   rvalid, rdata     : one-cycle read response (rdata holds otherwise)
//   err               : one-cycle pulse for an accepted out-of-range access
//   dbg_addr/dbg_data : combinational debug read port
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        req,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           din,
    input  logic [lanes(DATA_W)-1:0]    be,
    output logic                        ready,
    output logic                        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    input  logic [ADDR_W-1:0]           dbg_addr,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [lanes(DATA_W)-1:0] wr_be;
    logic [DATA_W-1:0]    rd_data;
    logic                 in_range;

    data_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_addr  (addr),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign ready    = (state_q == IDLE) && !clr;
    assign in_range = ({1'b0, addr} < DEPTH_L);

    // Next-state logic. The write port is shared: the sweep owns it in
    // CLEAR, accepted in-range writes own it in IDLE. A clr request in IDLE
    // only arms the sweep; the first zero write happens on the next edge.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        wr_be     = '1;

        case (state_q)
            CLEAR: begin
                wr_en = 1'b1;
                if (clr_ptr_q == LAST) begin
                    clr_ptr_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end else if (req) begin
                    err_d = !in_range;
                    if (we) begin
                        if (in_range) begin
                            wr_en   = 1'b1;
                            wr_addr = addr;
                            wr_data = din;
                            wr_be   = be;
                        end
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = in_range ? rd_data : '0;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // Reset blocks every memory write, including the sweep.
        if (!rst_n) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram
// Directed bench for data_ram: a default instance (24 x 256) and a
// DEPTH = 200 instance used for the out-of-range cases.
module tb_data_ram;

    logic        clk;
    logic        rst_n;

    logic        clr;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [23:0] din;
    logic [2:0]  be;
    logic        ready;
    logic        rvalid;
    logic [23:0] rdata;
    logic        err;
    logic [7:0]  dbg_addr;
    logic [23:0] dbg_data;

    logic        clr2;
    logic        req2;
    logic        we2;
    logic [7:0]  addr2;
    logic [23:0] din2;
    logic [2:0]  be2;
    logic        ready2;
    logic        rvalid2;
    logic [23:0] rdata2;
    logic        err2;
    logic [7:0]  dbg_addr2;
    logic [23:0] dbg_data2;

    int checks;
    int errors;
    int n;

    data_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .be       (be),
        .ready    (ready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    data_ram #(
        .DATA_W (24),
        .ADDR_W (8),
        .DEPTH  (200)
    ) dut200 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr2),
        .req      (req2),
        .we       (we2),
        .addr     (addr2),
        .din      (din2),
        .be       (be2),
        .ready    (ready2),
        .rvalid   (rvalid2),
        .rdata    (rdata2),
        .err      (err2),
        .dbg_addr (dbg_addr2),
        .dbg_data (dbg_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives the access inputs of the default instance.
    task automatic applyStimulus(input logic r, input logic w, input logic [7:0] a,
                                 input logic [23:0] d, input logic [2:0] b);
        req  = r;
        we   = w;
        addr = a;
        din  = d;
        be   = b;
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        dbg_addr  = 8'd0;
        applyStimulus(1'b0, 1'b0, 8'd0, 24'd0, 3'd0);
        clr2      = 1'b0;
        req2      = 1'b0;
        we2       = 1'b0;
        addr2     = 8'd0;
        din2      = 24'd0;
        be2       = 3'd0;
        dbg_addr2 = 8'd0;

        // Reset, let the sweep get part way, then reset again mid-sweep.
        repeat (3) tick();
        checkOutput("reset_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        repeat (50) tick();
        checkOutput("midsweep_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset2_ready", 32'(ready), 32'd0);
        checkOutput("reset2_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset2_rdata", 32'(rdata), 32'd0);
        checkOutput("reset2_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("sweep_len", 32'(n), 32'd256);
        checkOutput("ready200", 32'(ready2), 32'd1);
        for (int a = 0; a < 256; a++) begin
            dbg_addr = 8'(a);
            #1;
            checkOutput("dbg_zero", 32'(dbg_data), 32'd0);
        end

        // Full write to word 5, debug port must not change before the edge.
        dbg_addr = 8'd5;
        applyStimulus(1'b1, 1'b1, 8'd5, 24'hABCDEF, 3'b111);
        #1;
        checkOutput("dbg_before", 32'(dbg_data), 32'h0);
        tick();
        checkOutput("dbg_after", 32'(dbg_data), 32'hABCDEF);
        checkOutput("wr_rvalid", 32'(rvalid), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd5, 24'd0, 3'd0);
        tick();
        checkOutput("rd5_rvalid", 32'(rvalid), 32'd1);
        checkOutput("rd5_rdata", 32'(rdata), 32'hABCDEF);
        applyStimulus(1'b0, 1'b0, 8'd0, 24'd0, 3'd0);
        tick();
        checkOutput("idle_rvalid", 32'(rvalid), 32'd0);
        checkOutput("hold_rdata", 32'(rdata), 32'hABCDEF);

        // Partial write of the middle lane, then a be=0 no-op write.
        applyStimulus(1'b1, 1'b1, 8'd5, 24'h123456, 3'b010);
        tick();
        applyStimulus(1'b1, 1'b0, 8'd5, 24'd0, 3'd0);
        tick();
        checkOutput("partial_rdata", 32'(rdata), 32'hAB34EF);
        applyStimulus(1'b1, 1'b1, 8'd5, 24'hFFFFFF, 3'b000);
        tick();
        checkOutput("be0_noop", 32'(dbg_data), 32'hAB34EF);

        // Back-to-back reads of words 1..3.
        applyStimulus(1'b1, 1'b1, 8'd1, 24'h111111, 3'b111);
        tick();
        applyStimulus(1'b1, 1'b1, 8'd2, 24'h222222, 3'b111);
        tick();
        applyStimulus(1'b1, 1'b1, 8'd3, 24'h333333, 3'b111);
        tick();
        applyStimulus(1'b1, 1'b0, 8'd1, 24'd0, 3'd0);
        tick();
        checkOutput("b2b1_rvalid", 32'(rvalid), 32'd1);
        checkOutput("b2b1_rdata", 32'(rdata), 32'h111111);
        applyStimulus(1'b1, 1'b0, 8'd2, 24'd0, 3'd0);
        tick();
        checkOutput("b2b2_rvalid", 32'(rvalid), 32'd1);
        checkOutput("b2b2_rdata", 32'(rdata), 32'h222222);
        applyStimulus(1'b1, 1'b0, 8'd3, 24'd0, 3'd0);
        tick();
        checkOutput("b2b3_rvalid", 32'(rvalid), 32'd1);
        checkOutput("b2b3_rdata", 32'(rdata), 32'h333333);
        applyStimulus(1'b0, 1'b0, 8'd0, 24'd0, 3'd0);
        tick();
        checkOutput("b2b_end_rvalid", 32'(rvalid), 32'd0);

        // Out-of-range accesses on the 200-word instance.
        dbg_addr2 = 8'd199;
        req2 = 1'b1; we2 = 1'b1; addr2 = 8'd199; din2 = 24'h0F0F0F; be2 = 3'b111;
        tick();
        checkOutput("w199_err", 32'(err2), 32'd0);
        addr2 = 8'd250; din2 = 24'hFFFFFF;
        tick();
        checkOutput("w250_err", 32'(err2), 32'd1);
        checkOutput("w250_rvalid", 32'(rvalid2), 32'd0);
        checkOutput("w250_nochange", 32'(dbg_data2), 32'h0F0F0F);
        we2 = 1'b0; addr2 = 8'd199;
        tick();
        checkOutput("r199_rdata", 32'(rdata2), 32'h0F0F0F);
        checkOutput("r199_err", 32'(err2), 32'd0);
        addr2 = 8'd250;
        tick();
        checkOutput("r250_rvalid", 32'(rvalid2), 32'd1);
        checkOutput("r250_rdata", 32'(rdata2), 32'd0);
        checkOutput("r250_err", 32'(err2), 32'd1);
        req2 = 1'b0;
        dbg_addr2 = 8'd250;
        tick();
        checkOutput("err_pulse_end", 32'(err2), 32'd0);
        checkOutput("dbg250_zero", 32'(dbg_data2), 32'd0);

        // Soft clear: fill words 0..7, then clr together with a write.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i), 24'h010101 * 24'(i + 1), 3'b111);
            tick();
        end
        dbg_addr = 8'd7;
        #1;
        checkOutput("fill7", 32'(dbg_data), 32'h080808);
        clr = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'd0, 24'hFFFFFF, 3'b111);
        #1;
        checkOutput("clr_ready", 32'(ready), 32'd0);
        tick();
        clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0, 24'd0, 3'd0);
        n = 1;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("clr_busy_len", 32'(n), 32'd257);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 8'(a);
            #1;
            checkOutput("clr_word", 32'(dbg_data), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 8'd3, 24'd0, 3'd0);
        tick();
        checkOutput("clr_rd3_rvalid", 32'(rvalid), 32'd1);
        checkOutput("clr_rd3_rdata", 32'(rdata), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 24'd0, 3'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram.md
# data_ram

Parametrised single-port data memory with byte-lane write enables, a registered read port with valid/ready handshake, and a hardware clear sequencer. It replaces the fixed 24-bit × 256 data memory in the CPU datapath. A combinational debug read port replaces the fixed per-word taps. It sits between the CPU load/store stage and the debug/display logic.

## Interface
- DATA_W, 24: word width; must be a multiple of 8.
- ADDR_W, 8: address width.
- DEPTH, 256: number of words; DEPTH ≤ 2**ADDR_W.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clr  in  1  soft clear request; starts the clear sweep.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- be  in  DATA_W/8  byte-lane write enables; bit i covers din[8i+7:8i].
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  rdata valid; one-cycle pulse per accepted read.
- rdata  out  DATA_W  read data.
- err  out  1  one-cycle pulse: accepted access had addr ≥ DEPTH.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational mem[dbg_addr]; 0 if dbg_addr ≥ DEPTH.

## Operation
- FSM states: CLEAR, IDLE.
- CLEAR: writes 0 to mem[clr_ptr] each cycle, clr_ptr increments.
  - At clr_ptr == DEPTH-1, that word is written, clr_ptr returns to 0, and the FSM goes to IDLE.
- IDLE: clr=1 → CLEAR with clr_ptr = 0. No memory write occurs on that edge.
- ready = (state == IDLE) && !clr. A request is accepted on an edge where req && ready.
- Accepted write, addr < DEPTH: for each lane i with be[i]=1, mem[addr] lane i ← din lane i. Other lanes are unchanged. be = 0 is a legal no-op write.
- Accepted read, addr < DEPTH: rdata ← mem[addr] and rvalid ← 1 on the same edge.
- Accepted access, addr ≥ DEPTH: no memory change. err ← 1. A read also gives rvalid ← 1 and rdata ← 0.
- rdata holds its last value when rvalid = 0.
- Requests presented while ready = 0 are ignored, not queued. The requester must hold req.
- Debug read of a word being written on the current edge returns the old value until after that edge.

## Timing
- While rst_n = 0 at an edge:
  - state ← CLEAR, clr_ptr ← 0, rvalid ← 0, rdata ← 0, err ← 0.
  - ready = 0. No memory write.
- Memory contents are zero only after the sweep completes.
- Sweep length: DEPTH edges. Let E0 be the first edge with rst_n = 1.
  - Edges E0..E(DEPTH-1) clear words 0..DEPTH-1.
  - ready = 1 in the cycle after E(DEPTH-1). The first request can be accepted at E(DEPTH).
- rst_n = 0 during a sweep restarts it at word 0. clr = 1 during a sweep has no effect.
- Read latency: 1 cycle. Accepted at edge E → rvalid/rdata valid after E, for one cycle.
- Throughput: one access per cycle in IDLE.
- err is a single-cycle pulse, asserted after the accepting edge.

## Structure
- Package data_ram_pkg:
  - state enum {CLEAR, IDLE}.
  - Constant function lanes(DATA_W) = DATA_W/8.
- Sub-module data_ram_array holds the storage:
  - DEPTH × DATA_W array.
  - One write port with per-lane enables.
  - Two combinational read ports (access and debug).
- The top level holds the FSM, clr_ptr, the handshake and the range check.

## Test plan
- Reset with clr_ptr mid-sweep:
  - Hold rst_n = 0 for 3 cycles, then release → ready rises exactly DEPTH cycles later (256 with defaults).
  - dbg_data = 0 for every address 0..255.
- Full write then read: write addr 5, din 0xABCDEF, be 3'b111; next cycle read addr 5 → one cycle later rvalid = 1, rdata = 0xABCDEF.
- Partial write: then write addr 5, din 0x123456, be 3'b010 → read returns 0xAB34EF.
- Out of range (DEPTH = 200): write addr 250 → err pulse, no memory change. Read addr 250 → rvalid = 1, rdata = 0, err = 1.
- Soft clear:
  - Fill words 0..7 with nonzero values, pulse clr together with a write req → write not accepted, ready = 0 for DEPTH+1 cycles.
  - Afterwards all words read 0.
- Back-to-back reads of addresses 1, 2, 3 on consecutive cycles → three consecutive rvalid pulses with the matching data.
- Debug port tracks a write: dbg_addr = 5 shows the new value after the write edge, not before.
